scariv_fetch_queue: RTL and testbench

//  Circular FIFO between the ICache fetch stage and decode/dispatch. Buffers one fetch block per entry:

---
 rtl/scariv_fetch_queue.sv | 153 +++++++++++++++
 tb/tb_scariv_fetch_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/scariv_fetch_queue.sv
// ---------------------------------------------------------------------------
// scariv_fetch_queue
//
// Purpose:
//   Circular FIFO between the ICache fetch stage and decode/dispatch. Each
//   entry holds one fetch block: DISP_SIZE 32-bit instruction words, the
//   block PC and a per-word valid mask. The head entry is presented to
//   dispatch directly from storage. Dispatch retires a whole entry at a time.
//   A flush empties the queue in one cycle.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_flush_valid           empty the queue; overrides push and pop
//   i_f_valid / o_f_ready   fetch-side handshake (o_f_ready = not full)
//   i_f_pc/i_f_mask/i_f_data fetch block contents
//   o_disp_valid            head entry present (count != 0)
//   o_disp_pc/_mask/_inst   head entry contents (don't-care when not valid)
//   i_disp_ready            dispatch consumes the head entry
//   o_count                 number of occupied entries
// ---------------------------------------------------------------------------
module scariv_fetch_queue #(
  parameter int ENTRY_SIZE = 12,
  parameter int DATA_W     = 256,
  parameter int DISP_SIZE  = 8,
  parameter int VADDR_W    = 39,
  localparam int CNT_W     = $clog2(ENTRY_SIZE + 1),
  localparam int PTR_W     = (ENTRY_SIZE > 1) ? $clog2(ENTRY_SIZE) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush_valid,

  input  logic                 i_f_valid,
  output logic                 o_f_ready,
  input  logic [VADDR_W-1:0]   i_f_pc,
  input  logic [DISP_SIZE-1:0] i_f_mask,
  input  logic [DATA_W-1:0]    i_f_data,

  output logic                 o_disp_valid,
  output logic [VADDR_W-1:0]   o_disp_pc,
  output logic [DISP_SIZE-1:0] o_disp_mask,
  output logic [DATA_W-1:0]    o_disp_inst,
  input  logic                 i_disp_ready,

  output logic [CNT_W-1:0]     o_count
);

  // Each entry must hold exactly one dispatch group of 32-bit words.
  if (DATA_W != 32 * DISP_SIZE) begin : g_bad_width
    $error("scariv_fetch_queue: DATA_W must equal 32*DISP_SIZE");
  end

  // Pointer increment with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(ENTRY_SIZE - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Control state (reset)
  logic [PTR_W-1:0]      head_q,  head_d;
  logic [PTR_W-1:0]      tail_q,  tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ENTRY_SIZE-1:0] valid_q, valid_d;

  // Entry storage (no reset: contents are qualified by count/valid)
  logic [VADDR_W-1:0]    pc_q   [ENTRY_SIZE];
  logic [DISP_SIZE-1:0]  mask_q [ENTRY_SIZE];
  logic [DATA_W-1:0]     data_q [ENTRY_SIZE];

  logic full_w;
  logic push_w;
  logic pop_w;

  // Full depends only on the registered count, so a pop in the same cycle
  // never opens a slot for a push.
  assign full_w       = (count_q == CNT_W'(ENTRY_SIZE));
  assign o_f_ready    = !full_w;
  assign o_disp_valid = (count_q != '0);
  assign o_count      = count_q;

  assign push_w = i_f_valid && !full_w && !i_flush_valid;
  assign pop_w  = o_disp_valid && i_disp_ready && !i_flush_valid;

  // Head entry drives dispatch straight from storage: no fetch bypass.
  assign o_disp_pc   = pc_q[head_q];
  assign o_disp_mask = mask_q[head_q];
  assign o_disp_inst = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;

    if (push_w) begin
      tail_d          = next_ptr(tail_q);
      valid_d[tail_q] = 1'b1;
    end
    if (pop_w) begin
      head_d          = next_ptr(head_q);
      valid_d[head_q] = 1'b0;
    end

    unique case ({push_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (i_flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_w) begin
      pc_q[tail_q]   <= i_f_pc;
      mask_q[tail_q] <= i_f_mask;
      data_q[tail_q] <= i_f_data;
    end
  end

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge i_clk) disable iff (i_reset)
    count_q <= CNT_W'(ENTRY_SIZE));
  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !(push_w && full_w));
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_reset)
    !(pop_w && !o_disp_valid));
  a_head_valid: assert property (@(posedge i_clk) disable iff (i_reset)
    o_disp_valid == valid_q[head_q]);
`endif

endmodule

// File: tb/tb_scariv_fetch_queue.sv
module tb_scariv_fetch_queue;

  localparam int ENTRY_SIZE = 12;
  localparam int DATA_W     = 256;
  localparam int DISP_SIZE  = 8;
  localparam int VADDR_W    = 39;
  localparam int CNT_W      = $clog2(ENTRY_SIZE + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 f_valid = 1'b0;
  logic                 f_ready;
  logic [VADDR_W-1:0]   f_pc = '0;
  logic [DISP_SIZE-1:0] f_mask = '0;
  logic [DATA_W-1:0]    f_data = '0;
  logic                 d_valid;
  logic [VADDR_W-1:0]   d_pc;
  logic [DISP_SIZE-1:0] d_mask;
  logic [DATA_W-1:0]    d_inst;
  logic                 d_ready = 1'b0;
  logic [CNT_W-1:0]     count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scariv_fetch_queue #(
    .ENTRY_SIZE(ENTRY_SIZE), .DATA_W(DATA_W), .DISP_SIZE(DISP_SIZE), .VADDR_W(VADDR_W)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_flush_valid(flush),
    .i_f_valid(f_valid), .o_f_ready(f_ready), .i_f_pc(f_pc), .i_f_mask(f_mask), .i_f_data(f_data),
    .o_disp_valid(d_valid), .o_disp_pc(d_pc), .o_disp_mask(d_mask), .o_disp_inst(d_inst),
    .i_disp_ready(d_ready), .o_count(count)
  );

  // Instruction ramp derived from the PC: word k = pc[31:0] + k.
  function automatic logic [DATA_W-1:0] data_for(input logic [VADDR_W-1:0] p);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DISP_SIZE; k++) d[32*k +: 32] = p[31:0] + 32'(k);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic fv, input logic [VADDR_W-1:0] pc,
                       input logic [DISP_SIZE-1:0] m, input logic dr);
    flush   = fl;
    f_valid = fv;
    f_pc    = pc;
    f_mask  = m;
    f_data  = data_for(pc);
    d_ready = dr;
  endtask

  typedef struct {
    logic                 fl;
    logic                 fv;
    logic [VADDR_W-1:0]   pc;
    logic [DISP_SIZE-1:0] mask;
    logic                 dr;
    int                   ecnt;
    logic                 edv;
    logic                 efr;
    logic [VADDR_W-1:0]   epc;
    logic [DISP_SIZE-1:0] emask;
  } vec_t;

  vec_t vecs[9];
  logic [VADDR_W-1:0] q[$];
  logic [VADDR_W-1:0] pc_now;
  logic fr_now, dv_now, push, pop;
  int sent, rcvd;

  initial begin
    //           fl    fv    pc        mask   dr    cnt dv    fr    head pc   head mask
    vecs[0] = '{1'b0, 1'b1, 39'h1000, 8'hFF, 1'b0, 1, 1'b1, 1'b1, 39'h1000, 8'hFF};
    vecs[1] = '{1'b0, 1'b0, 39'h0,    8'h00, 1'b1, 0, 1'b0, 1'b1, 39'h0,    8'h00};
    vecs[2] = '{1'b0, 1'b1, 39'h1020, 8'h00, 1'b1, 1, 1'b1, 1'b1, 39'h1020, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 39'h1040, 8'h0F, 1'b1, 1, 1'b1, 1'b1, 39'h1040, 8'h0F};
    vecs[4] = '{1'b0, 1'b1, 39'h1060, 8'hF0, 1'b0, 2, 1'b1, 1'b1, 39'h1040, 8'h0F};
    vecs[5] = '{1'b0, 1'b0, 39'h0,    8'h00, 1'b1, 1, 1'b1, 1'b1, 39'h1060, 8'hF0};
    vecs[6] = '{1'b1, 1'b1, 39'h1080, 8'hFF, 1'b1, 0, 1'b0, 1'b1, 39'h0,    8'h00};
    vecs[7] = '{1'b0, 1'b1, 39'h10A0, 8'h3C, 1'b0, 1, 1'b1, 1'b1, 39'h10A0, 8'h3C};
    vecs[8] = '{1'b0, 1'b0, 39'h0,    8'h00, 1'b1, 0, 1'b0, 1'b1, 39'h0,    8'h00};

    // Reset state, checked while reset is held and before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_disp_valid", d_valid, 0);
    chk("rst_f_ready", f_ready, 1);
    chk("rst_count", count, 0);
    cyc();
    rst = 1'b0;

    // Table-driven single-cycle behaviour.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].fl, vecs[i].fv, vecs[i].pc, vecs[i].mask, vecs[i].dr);
      cyc();
      chk($sformatf("vec%0d_count", i), count, vecs[i].ecnt);
      chk($sformatf("vec%0d_disp_valid", i), d_valid, vecs[i].edv);
      chk($sformatf("vec%0d_f_ready", i), f_ready, vecs[i].efr);
      if (vecs[i].edv) begin
        chk($sformatf("vec%0d_pc", i), d_pc, vecs[i].epc);
        chk($sformatf("vec%0d_mask", i), d_mask, vecs[i].emask);
        chk($sformatf("vec%0d_inst", i), d_inst, data_for(vecs[i].epc));
      end
    end

    // Fill to full with dispatch stalled.
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      drive(0, 1, 39'h3000 + 39'(32 * i), 8'hFF, 0);
      cyc();
      chk("fill_count", count, i + 1);
    end
    chk("full_f_ready", f_ready, 0);
    drive(0, 1, 39'h3800, 8'hFF, 0);
    cyc();
    chk("full_refuse_count", count, ENTRY_SIZE);
    chk("full_head_pc", d_pc, 39'h3000);

    // Push and pop together at full: only the pop happens.
    drive(0, 1, 39'h3800, 8'hFF, 1);
    cyc();
    chk("full_pushpop_count", count, ENTRY_SIZE - 1);
    chk("full_pushpop_f_ready", f_ready, 1);
    chk("full_pushpop_head", d_pc, 39'h3020);
    for (int i = 1; i < ENTRY_SIZE; i++) begin
      drive(0, 0, 39'h0, 8'h00, 1);
      chk("drain_pc", d_pc, 39'h3000 + 39'(32 * i));
      cyc();
    end
    chk("drain_count", count, 0);
    chk("drain_disp_valid", d_valid, 0);

    // Stream 40 blocks with random back-pressure against a queue model.
    sent = 0;
    rcvd = 0;
    q.delete();
    for (int c = 0; c < 2000 && rcvd < 40; c++) begin
      fr_now = f_ready;
      dv_now = d_valid;
      pc_now = d_pc;
      drive(0, sent < 40, 39'h4000 + 39'(32 * sent), 8'hFF, 1'($urandom_range(0, 1)));
      push = f_valid && fr_now;
      pop  = dv_now && d_ready;
      if (pop) begin
        if (q.size() == 0) begin
          chk("stream_pop_empty", 1, 0);
        end else begin
          chk("stream_pc", pc_now, q[0]);
          void'(q.pop_front());
        end
        rcvd++;
      end
      if (push) begin
        q.push_back(f_pc);
        sent++;
      end
      cyc();
      chk("stream_count", count, q.size());
    end
    chk("stream_done", rcvd, 40);
    drive(0, 0, 39'h0, 8'h00, 1);
    while (d_valid && rcvd < 200) begin cyc(); rcvd++; end

    // Flush with 5 queued, together with a push and a pop.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 39'h6000 + 39'(32 * i), 8'hFF, 0);
      cyc();
    end
    chk("preflush_count", count, 5);
    drive(1, 1, 39'h6100, 8'hFF, 1);
    cyc();
    chk("flush_count", count, 0);
    chk("flush_disp_valid", d_valid, 0);
    chk("flush_f_ready", f_ready, 1);
    drive(0, 1, 39'h2000, 8'hAA, 0);
    cyc();
    chk("postflush_count", count, 1);
    chk("postflush_pc", d_pc, 39'h2000);
    chk("postflush_mask", d_mask, 8'hAA);
    drive(0, 0, 39'h0, 8'h00, 1);
    cyc();

    // Asynchronous reset with 7 entries queued.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 39'h7000 + 39'(32 * i), 8'hFF, 0);
      cyc();
    end
    drive(0, 0, 39'h0, 8'h00, 0);
    chk("prereset_count", count, 7);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_disp_valid", d_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_f_ready", f_ready, 1);
    cyc();
    rst = 1'b0;
    drive(0, 1, 39'h5000, 8'h81, 0);
    cyc();
    chk("postrst_count", count, 1);
    chk("postrst_pc", d_pc, 39'h5000);
    chk("postrst_inst", d_inst, data_for(39'h5000));
    drive(0, 0, 39'h0, 8'h00, 0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
